// File: rtl/park_pkg.sv
// Shared types and default constants for the parking gate controller.
package park_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ENTRY_OPEN = 2'd1,
        EXIT_OPEN  = 2'd2,
        REJECT     = 2'd3
    } park_gate_state_t;

    localparam int CAPACITY_DEF    = 8;
    localparam int OPEN_CYCLES_DEF = 16;
    localparam int DENY_CYCLES_DEF = 8;
    localparam int TMR_W           = 8;

endpackage

// File: rtl/park_gate_rise_det.sv
// Registered 1-bit rising-edge detector; pulse is high while the input is 1
// and its previous sampled value was 0.
module park_rise_det (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_rise
);

    logic r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_prev <= 1'b0;
        else          r_prev <= i_d;
    end

    assign o_rise = i_d & ~r_prev;

endmodule

// File: rtl/park_gate_ctrl.sv
// Barrier, occupancy and timeout control for a parking lot gate.
// Optional sticky timeout alarm enabled by defining PARK_GATE_TIMEOUT_ALARM_EN.
module park_gate_ctrl
    import park_pkg::*;
#(
    parameter int CAPACITY    = CAPACITY_DEF,
    parameter int CNT_W       = 4,
    parameter int OPEN_CYCLES = OPEN_CYCLES_DEF,
    parameter int DENY_CYCLES = DENY_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             grant,
    input  logic             deny,
    input  logic             leave_req,
    input  logic             pass_sensor,
    output logic             gate_open,
    output logic             green_led,
    output logic             red_led,
    output logic [CNT_W-1:0] occupancy,
    output logic             full,
    output logic             timeout,
    output logic             alarm
);

    logic w_grant_rise, w_deny_rise, w_leave_rise, w_pass_rise;
    logic w_grant_block;

    park_rise_det u_grant_det (.i_clk(clk), .i_rst_n(reset), .i_d(grant),       .o_rise(w_grant_rise));
    park_rise_det u_deny_det  (.i_clk(clk), .i_rst_n(reset), .i_d(deny),        .o_rise(w_deny_rise));
    park_rise_det u_leave_det (.i_clk(clk), .i_rst_n(reset), .i_d(leave_req),   .o_rise(w_leave_rise));
    park_rise_det u_pass_det  (.i_clk(clk), .i_rst_n(reset), .i_d(pass_sensor), .o_rise(w_pass_rise));

    park_gate_state_t r_state, w_state_nxt;
    logic [TMR_W-1:0] r_timer, w_timer_nxt;
    logic [CNT_W-1:0] r_occ,   w_occ_nxt;
    logic             r_timeout, w_timeout_nxt;
    logic             r_alarm,   w_alarm_nxt;
    logic             w_full;

    assign w_full = (r_occ == CNT_W'(CAPACITY));

`ifdef PARK_GATE_TIMEOUT_ALARM_EN
    assign w_grant_block = r_alarm;
`else
    assign w_grant_block = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_timer   <= '0;
            r_occ     <= '0;
            r_timeout <= 1'b0;
            r_alarm   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_occ     <= w_occ_nxt;
            r_timeout <= w_timeout_nxt;
            r_alarm   <= w_alarm_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = r_timer;
        w_occ_nxt     = r_occ;
        w_timeout_nxt = 1'b0;
        w_alarm_nxt   = r_alarm;
        unique case (r_state)
            IDLE: begin
                // Exit has priority; a coincident grant edge is simply dropped.
                if (w_leave_rise && r_occ != '0) begin
                    w_state_nxt = EXIT_OPEN;
                    w_timer_nxt = TMR_W'(OPEN_CYCLES - 1);
                end else if (w_grant_rise && !w_full && !w_grant_block) begin
                    w_state_nxt = ENTRY_OPEN;
                    w_timer_nxt = TMR_W'(OPEN_CYCLES - 1);
                end else if (w_grant_rise || w_deny_rise) begin
                    w_state_nxt = REJECT;
                    w_timer_nxt = TMR_W'(DENY_CYCLES - 1);
                end
            end
            ENTRY_OPEN, EXIT_OPEN: begin
                if (w_pass_rise) begin
                    w_state_nxt = IDLE;
                    w_alarm_nxt = 1'b0;
                    if (r_state == ENTRY_OPEN) begin
                        if (r_occ < CNT_W'(CAPACITY)) w_occ_nxt = r_occ + 1'b1;
                    end else if (r_occ != '0) begin
                        w_occ_nxt = r_occ - 1'b1;
                    end
                end else if (r_timer == '0) begin
                    w_state_nxt   = IDLE;
                    w_timeout_nxt = 1'b1;
                    w_alarm_nxt   = 1'b1;
                end else begin
                    w_timer_nxt = r_timer - 1'b1;
                end
            end
            REJECT: begin
                if (r_timer == '0) w_state_nxt = IDLE;
                else               w_timer_nxt = r_timer - 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase
`ifndef PARK_GATE_TIMEOUT_ALARM_EN
        w_alarm_nxt = 1'b0;
`endif
    end

    assign gate_open = (r_state == ENTRY_OPEN) || (r_state == EXIT_OPEN);
    assign green_led = gate_open;
    assign red_led   = (r_state == REJECT);
    assign occupancy = r_occ;
    assign full      = w_full;
    assign timeout   = r_timeout;
    assign alarm     = r_alarm;

endmodule

// File: doc/park_gate_ctrl.md
Name: park_gate_ctrl

Overview:
- Downstream of the parking access controller.
- Consumes its level-type success/failure verdicts and a gate-side pass sensor.
- Drives the entry/exit barrier, maintains the lot occupancy count and full flag, and times out a barrier left open with no car passing.
- Output feeds the lot status display and indicator LEDs.

Parameters:
CAPACITY, 8, number of parking slots; full asserted when occupancy == CAPACITY
CNT_W, 4, occupancy width; must satisfy 2**CNT_W > CAPACITY
OPEN_CYCLES, 16, clock cycles the barrier stays open waiting for the pass sensor
DENY_CYCLES, 8, clock cycles red_led is held after a denial

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
grant  input  1  access-granted level from the access controller
deny  input  1  access-denied level from the access controller
leave_req  input  1  exit-lane request sensor, level
pass_sensor  input  1  car-through-barrier sensor, level
gate_open  output  1  barrier open command
green_led  output  1  high while the barrier is open
red_led  output  1  high while a denial or full-reject is shown
occupancy  output  CNT_W  cars currently parked
full  output  1  occupancy == CAPACITY
timeout  output  1  one-cycle pulse when an open window expires unused
alarm  output  1  sticky timeout alarm (optional feature)

Behaviour:
- Reset (reset == 0, asynchronous):
  - state = IDLE
  - occupancy = 0, timer = 0
  - all outputs = 0
  - edge-detect history regs = 0
- Reset mid-operation closes the barrier immediately and discards the count.
- Inputs are synchronous to clk.
- grant, deny, leave_req and pass_sensor are rising-edge detected: a 1-cycle pulse when the registered previous value is 0 and the current value is 1. Held levels never retrigger.
- States: IDLE, ENTRY_OPEN, EXIT_OPEN, REJECT.
- IDLE priority, highest first:
  - leave_req edge with occupancy > 0 -> EXIT_OPEN.
  - grant edge with !full -> ENTRY_OPEN.
  - grant edge with full -> REJECT.
  - deny edge -> REJECT.
  - leave_req edge with occupancy == 0 is ignored.
  - Simultaneous leave_req and grant edges: exit wins; the grant edge is dropped, not queued.
- ENTRY_OPEN / EXIT_OPEN:
  - On entry, timer loads OPEN_CYCLES-1.
  - gate_open = green_led = 1, registered, asserting the cycle after the triggering edge.
  - pass_sensor edge: occupancy +1 (entry) or -1 (exit), registered the same cycle; -> IDLE.
  - Timer reaching 0 with no pass: -> IDLE, occupancy unchanged, timeout = 1 for one cycle.
  - pass_sensor edge on the terminal timer cycle counts as a pass; no timeout pulse.
- REJECT:
  - red_led = 1; timer loads DENY_CYCLES-1; -> IDLE when the timer reaches 0.
- Edges of grant, deny and leave_req arriving in any non-IDLE state are ignored.
- Arithmetic and flags:
  - Occupancy saturates: never exceeds CAPACITY, never wraps below 0.
  - full is combinational from occupancy.
- gate_open is 0 in IDLE and REJECT.
- gate_open and red_led are never both 1.

Optional Feature:
- Macro: PARK_GATE_TIMEOUT_ALARM_EN.
- Defined:
  - alarm sets on any timeout pulse and is sticky.
  - Cleared only by reset or by the next successful pass_sensor edge.
  - While alarm = 1, grant edges in IDLE go to REJECT; leave_req still works.
- Undefined:
  - alarm tied to 0; timeout pulse is still produced.
  - No grant blocking.

Decomposition:
- Package park_pkg holds:
  - state enum park_gate_state_t {IDLE, ENTRY_OPEN, EXIT_OPEN, REJECT}
  - default CAPACITY/OPEN_CYCLES/DENY_CYCLES constants
  - timer width constant TMR_W = 8
- Sub-module park_rise_det: 1-bit registered rising-edge detector with async active-low reset.
  - Instantiated four times: grant, deny, leave_req, pass_sensor.
- Remainder (FSM, timer, occupancy counter) is one always block plus output decode.

Test Plan:
- Reset release, grant 0->1, pass_sensor pulse 5 cycles later -> gate_open high 1 cycle after grant edge; occupancy 0->1; gate_open drops the same cycle as the pass; timeout stays 0.
- grant edge, no pass for 16 cycles -> gate_open low after cycle 16; timeout one-cycle pulse; occupancy unchanged. With PARK_GATE_TIMEOUT_ALARM_EN, alarm = 1 and the next grant gives red_led for 8 cycles.
- Eight grant+pass sequences -> occupancy = 8, full = 1. Ninth grant -> red_led 8 cycles, gate_open stays 0, occupancy stays 8.
- occupancy = 3; leave_req and grant rise the same cycle -> EXIT_OPEN; a pass gives occupancy = 2. The dropped grant does not reopen the barrier.
- occupancy = 0, leave_req edge -> no state change, gate_open = 0; deny edge -> red_led high exactly 8 cycles.
- Mid ENTRY_OPEN, pull reset low asynchronously between clock edges -> gate_open, occupancy and green_led go 0 immediately without waiting for a clock; after release, state is IDLE.
